// File: rtl/gpio_pkg.sv
// Mode encoding shared by the GPIO pattern generator top and its channel slices.
package gpio_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

endpackage

// File: rtl/gpio_chan.sv
// One GPIO pattern channel: holds its own mode/period/duty and advances its
// counter and output level once per prescaler tick; a config write restarts it.
module gpio_chan
  import gpio_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter mode_e       RST_MODE   = MODE_BLINK,
  parameter int unsigned RST_PERIOD = 1000
) (
  input  logic             clk50,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             we_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] duty_i,
  output logic             lvl_o
);

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;

  logic [CNT_W-1:0] lastCnt;
  logic [CNT_W-1:0] cntNext;

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      mode_q   <= RST_MODE;
      period_q <= CNT_W'(RST_PERIOD);
      duty_q   <= '0;
      cnt_q    <= '0;
      lvl_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      lvl_q    <= lvl_d;
    end
  end

  // A zero period behaves like a period of one, so period-1 never wraps.
  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q;
    lvl_d    = lvl_q;
    lastCnt  = (period_q == '0) ? '0 : period_q - CNT_W'(1);
    cntNext  = (cnt_q >= lastCnt) ? '0 : cnt_q + CNT_W'(1);

    if (we_i) begin
      mode_d   = mode_e'(mode_i);
      period_d = period_i;
      duty_d   = duty_i;
      cnt_d    = '0;
      lvl_d    = 1'b0;
    end else if (tick_i) begin
      unique case (mode_q)
        MODE_OFF: begin
          cnt_d = '0;
          lvl_d = 1'b0;
        end
        MODE_ON: begin
          cnt_d = '0;
          lvl_d = 1'b1;
        end
        MODE_BLINK: begin
          cnt_d = cntNext;
          if (cnt_q >= lastCnt) begin
            lvl_d = ~lvl_q;
          end
        end
        MODE_PWM: begin
          if (period_q == '0) begin
            cnt_d = '0;
            lvl_d = 1'b0;
          end else begin
            cnt_d = cntNext;
            lvl_d = (cntNext < duty_q);
          end
        end
      endcase
    end
  end

  assign lvl_o = lvl_q;

endmodule

// File: rtl/gpio_pattern_gen.sv
// Multi-channel GPIO pattern driver: a shared prescaler tick drives CHANNELS
// independent OFF/ON/BLINK/PWM channels, each reprogrammable via one write port.
module gpio_pattern_gen
  import gpio_pkg::*;
#(
  parameter int unsigned FREQ        = 50_000_000,
  parameter int unsigned TICK_HZ     = 1000,
  parameter int unsigned CHANNELS    = 8,
  parameter int unsigned CNT_W       = 16,
  parameter bit          ACTIVE_HIGH = 1'b1,
  parameter logic [1:0]  RST_MODE    = 2'd2,
  parameter int unsigned RST_PERIOD  = 1000,
  localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk50,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_duty,
  output logic                tick,
  output logic [CHANNELS-1:0] gpio
);

  localparam int unsigned DIV   = FREQ / TICK_HZ;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : gBadDiv
    $error("gpio_pattern_gen: FREQ/TICK_HZ must be at least 1");
  end

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                tick_q, tick_d;
  logic [CH_W:0]       chExt;
  logic                chValid;
  logic [CHANNELS-1:0] chWe;
  logic [CHANNELS-1:0] lvlVec;

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    pre_d  = pre_q + PRE_W'(1);
    tick_d = 1'b0;
    if (pre_q == PRE_W'(DIV - 1)) begin
      pre_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Widen by one bit so out-of-range channel numbers are rejected for any CHANNELS.
  assign chExt   = {1'b0, cfg_ch};
  assign chValid = (chExt < (CH_W + 1)'(CHANNELS));

  always_comb begin
    chWe = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      chWe[i] = cfg_we && chValid && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : gChan
    gpio_chan #(
      .CNT_W     (CNT_W),
      .RST_MODE  (mode_e'(RST_MODE)),
      .RST_PERIOD(RST_PERIOD)
    ) uChan (
      .clk50   (clk50),
      .rst_n   (rst_n),
      .tick_i  (tick_q),
      .we_i    (chWe[i]),
      .mode_i  (cfg_mode),
      .period_i(cfg_period),
      .duty_i  (cfg_duty),
      .lvl_o   (lvlVec[i])
    );
  end

  assign tick = tick_q;
  assign gpio = ACTIVE_HIGH ? lvlVec : ~lvlVec;

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// Directed bench for gpio_pattern_gen: a main 4-channel instance, an inverted
// 4-channel instance and a 5-channel instance for out-of-range addresses.
module tb_gpio_pattern_gen;

  logic       clk50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfgWeMain = 1'b0;
  logic       cfgWeInv = 1'b0;
  logic       cfgWeOdd = 1'b0;
  logic [2:0] cfgCh = '0;
  logic [1:0] cfgMode = '0;
  logic [7:0] cfgPeriod = '0;
  logic [7:0] cfgDuty = '0;

  logic       tickMain, tickInv, tickOdd;
  logic [3:0] gpioMain, gpioInv;
  logic [4:0] gpioOdd;

  int errors = 0;
  int checks = 0;
  int now = 0;

  always #5 clk50 = ~clk50;

  gpio_pattern_gen #(
    .FREQ(10), .TICK_HZ(1), .CHANNELS(4), .CNT_W(8),
    .ACTIVE_HIGH(1'b1), .RST_MODE(2'd2), .RST_PERIOD(2)
  ) dutMain (
    .clk50(clk50), .rst_n(rst_n), .cfg_we(cfgWeMain), .cfg_ch(cfgCh[1:0]),
    .cfg_mode(cfgMode), .cfg_period(cfgPeriod), .cfg_duty(cfgDuty),
    .tick(tickMain), .gpio(gpioMain)
  );

  gpio_pattern_gen #(
    .FREQ(10), .TICK_HZ(1), .CHANNELS(4), .CNT_W(8),
    .ACTIVE_HIGH(1'b0), .RST_MODE(2'd2), .RST_PERIOD(2)
  ) dutInv (
    .clk50(clk50), .rst_n(rst_n), .cfg_we(cfgWeInv), .cfg_ch(cfgCh[1:0]),
    .cfg_mode(cfgMode), .cfg_period(cfgPeriod), .cfg_duty(cfgDuty),
    .tick(tickInv), .gpio(gpioInv)
  );

  gpio_pattern_gen #(
    .FREQ(10), .TICK_HZ(1), .CHANNELS(5), .CNT_W(8),
    .ACTIVE_HIGH(1'b1), .RST_MODE(2'd2), .RST_PERIOD(2)
  ) dutOdd (
    .clk50(clk50), .rst_n(rst_n), .cfg_we(cfgWeOdd), .cfg_ch(cfgCh),
    .cfg_mode(cfgMode), .cfg_period(cfgPeriod), .cfg_duty(cfgDuty),
    .tick(tickOdd), .gpio(gpioOdd)
  );

  task checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %b expected %b", tag, now, observed, expected);
    end
  endtask

  // 'now' counts falling edges since the last reset release; outputs sampled
  // at falling edge N reflect the state after rising edge N.
  task goTo(input int t);
    while (now < t) begin
      @(negedge clk50);
      now++;
    end
  endtask

  task applyStimulus(input int target, input logic [2:0] ch, input logic [1:0] mode,
                     input logic [7:0] period, input logic [7:0] duty);
    cfgCh     = ch;
    cfgMode   = mode;
    cfgPeriod = period;
    cfgDuty   = duty;
    cfgWeMain = (target == 0);
    cfgWeInv  = (target == 1);
    cfgWeOdd  = (target == 2);
    @(negedge clk50);
    now++;
    cfgWeMain = 1'b0;
    cfgWeInv  = 1'b0;
    cfgWeOdd  = 1'b0;
  endtask

  task doReset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk50);
    checkOutput("rst_gpio_main", {4'b0, gpioMain}, 8'b0000_0000);
    checkOutput("rst_tick_main", {7'b0, tickMain}, 8'd0);
    checkOutput("rst_gpio_inv", {4'b0, gpioInv}, 8'b0000_1111);
    checkOutput("rst_gpio_odd", {3'b0, gpioOdd}, 8'b0000_0000);
    rst_n = 1'b1;
    now = 0;
  endtask

  initial begin
    $display("[TB] start");
    doReset(3);

    goTo(9);   checkOutput("tick_before_first", {7'b0, tickMain}, 8'd0);
    goTo(10);  checkOutput("tick_first", {7'b0, tickMain}, 8'd1);
    goTo(11);  checkOutput("tick_one_cycle", {7'b0, tickMain}, 8'd0);
    goTo(20);  checkOutput("tick_second", {7'b0, tickMain}, 8'd1);
               checkOutput("blink2_before_toggle", {4'b0, gpioMain}, 8'b0000_0000);
    goTo(21);  checkOutput("blink2_toggle_hi", {4'b0, gpioMain}, 8'b0000_1111);
    goTo(40);  checkOutput("blink2_hold_hi", {4'b0, gpioMain}, 8'b0000_1111);
    goTo(41);  checkOutput("blink2_toggle_lo", {4'b0, gpioMain}, 8'b0000_0000);

    // ch2 blink, half-period 3 ticks
    goTo(44);
    applyStimulus(0, 3'd2, 2'd2, 8'd3, 8'd0);
    checkOutput("blink3_restart", {4'b0, gpioMain}, 8'b0000_0000);
    goTo(70);  checkOutput("blink3_still_lo", {4'b0, gpioMain}, 8'b0000_1011);
    goTo(71);  checkOutput("blink3_first_hi", {4'b0, gpioMain}, 8'b0000_1111);
    goTo(81);  checkOutput("blink3_others_lo", {4'b0, gpioMain}, 8'b0000_0100);
    goTo(100); checkOutput("blink3_hold_hi", {4'b0, gpioMain}, 8'b0000_0100);
    goTo(101); checkOutput("blink3_back_lo", {4'b0, gpioMain}, 8'b0000_1011);

    // ch1 PWM period 4 duty 1
    goTo(104);
    applyStimulus(0, 3'd1, 2'd3, 8'd4, 8'd1);
    goTo(111); checkOutput("pwm1_t1", {7'b0, gpioMain[1]}, 8'd0);
    goTo(140); checkOutput("pwm1_t3", {7'b0, gpioMain[1]}, 8'd0);
    goTo(141); checkOutput("pwm1_hi", {7'b0, gpioMain[1]}, 8'd1);
    goTo(150); checkOutput("pwm1_hi_hold", {7'b0, gpioMain[1]}, 8'd1);
    goTo(151); checkOutput("pwm1_lo", {7'b0, gpioMain[1]}, 8'd0);
    goTo(181); checkOutput("pwm1_hi_again", {7'b0, gpioMain[1]}, 8'd1);

    // duty == period
    goTo(184);
    applyStimulus(0, 3'd1, 2'd3, 8'd4, 8'd4);
    checkOutput("pwm_full_restart", {7'b0, gpioMain[1]}, 8'd0);
    goTo(190); checkOutput("pwm_full_pre", {7'b0, gpioMain[1]}, 8'd0);
    goTo(191); checkOutput("pwm_full_t1", {7'b0, gpioMain[1]}, 8'd1);
    goTo(221); checkOutput("pwm_full_wrap", {7'b0, gpioMain[1]}, 8'd1);
    goTo(230); checkOutput("pwm_full_hold", {7'b0, gpioMain[1]}, 8'd1);

    // duty 0
    goTo(234);
    applyStimulus(0, 3'd1, 2'd3, 8'd4, 8'd0);
    goTo(241); checkOutput("pwm_zero_t1", {7'b0, gpioMain[1]}, 8'd0);
    goTo(271); checkOutput("pwm_zero_wrap", {7'b0, gpioMain[1]}, 8'd0);

    // period 0 with nonzero duty
    goTo(284);
    applyStimulus(0, 3'd1, 2'd3, 8'd0, 8'd5);
    goTo(291); checkOutput("pwm_p0_t1", {7'b0, gpioMain[1]}, 8'd0);
    goTo(301); checkOutput("pwm_p0_t2", {7'b0, gpioMain[1]}, 8'd0);
    goTo(321); checkOutput("pwm_p0_t4", {7'b0, gpioMain[1]}, 8'd0);

    // write to ch0 lands on the tick cycle
    goTo(340);
    checkOutput("coll_tick", {7'b0, tickMain}, 8'd1);
    checkOutput("coll_before", {4'b0, gpioMain}, 8'b0000_0100);
    applyStimulus(0, 3'd0, 2'd3, 8'd4, 8'd2);
    checkOutput("coll_after", {4'b0, gpioMain}, 8'b0000_1000);
    goTo(351); checkOutput("coll_pwm_t1", {7'b0, gpioMain[0]}, 8'd1);
    goTo(361); checkOutput("coll_pwm_t2", {7'b0, gpioMain[0]}, 8'd0);
    goTo(381); checkOutput("coll_pwm_t4", {7'b0, gpioMain[0]}, 8'd1);
    goTo(391); checkOutput("coll_pwm_t5", {7'b0, gpioMain[0]}, 8'd1);
    goTo(401); checkOutput("coll_pwm_t6", {7'b0, gpioMain[0]}, 8'd0);

    // out-of-range channel numbers on the 5-channel instance
    goTo(404);
    applyStimulus(2, 3'd5, 2'd1, 8'd0, 8'd0);
    applyStimulus(2, 3'd7, 2'd1, 8'd0, 8'd0);
    goTo(411); checkOutput("badch_t1", {3'b0, gpioOdd}, 8'b0000_0000);
    goTo(421); checkOutput("badch_t2", {3'b0, gpioOdd}, 8'b0001_1111);
    goTo(441); checkOutput("badch_t4", {3'b0, gpioOdd}, 8'b0000_0000);

    // inverted polarity
    goTo(444);
    applyStimulus(1, 3'd3, 2'd0, 8'd2, 8'd0);
    checkOutput("inv_off_write", {4'b0, gpioInv}, 8'b0000_1111);
    goTo(461); checkOutput("inv_off_others_on", {4'b0, gpioInv}, 8'b0000_1000);
    goTo(481); checkOutput("inv_off_all_idle", {4'b0, gpioInv}, 8'b0000_1111);
    goTo(484);
    applyStimulus(1, 3'd3, 2'd1, 8'd2, 8'd0);
    checkOutput("inv_on_restart", {4'b0, gpioInv}, 8'b0000_1111);
    goTo(491); checkOutput("inv_on_active", {4'b0, gpioInv}, 8'b0000_0111);
    goTo(501); checkOutput("inv_on_all_active", {4'b0, gpioInv}, 8'b0000_0000);

    // one-cycle reset in the middle of a prescaler period
    goTo(505);
    doReset(1);
    goTo(9);   checkOutput("mrst_tick_pre", {7'b0, tickMain}, 8'd0);
    goTo(10);  checkOutput("mrst_tick_first", {7'b0, tickMain}, 8'd1);
    goTo(20);  checkOutput("mrst_blink_lo", {4'b0, gpioMain}, 8'b0000_0000);
    goTo(21);  checkOutput("mrst_blink_hi", {4'b0, gpioMain}, 8'b0000_1111);
               checkOutput("mrst_inv_hi", {4'b0, gpioInv}, 8'b0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
